// File: rtl/fft_bfly_stage0.sv
// Stage-0 radix-2 butterfly of the 16-lane parallel 64-point FFT.
// Pairs x[n] with x[n+32] via a two-block buffer; emits sum blocks, then difference blocks.
module fft_bfly_stage0 #(
  parameter int IN_W  = 9,
  parameter int ARRAY = 16
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         din_en,
  input  logic                         din_sop,
  input  logic [ARRAY-1:0][IN_W-1:0]   din_re,
  input  logic [ARRAY-1:0][IN_W-1:0]   din_im,
  output logic                         bfly_en,
  output logic [1:0]                   bfly_cnt,
  output logic [ARRAY-1:0][IN_W:0]     dout_re,
  output logic [ARRAY-1:0][IN_W:0]     dout_im
);

  localparam int OW = IN_W + 1;

  typedef enum logic [1:0] {
    DR_IDLE = 2'd0,
    DR_BUF0 = 2'd1,
    DR_BUF1 = 2'd2
  } drain_t;

  function automatic logic signed [IN_W:0] sext(input logic [IN_W-1:0] v);
    return {v[IN_W-1], v};
  endfunction

  logic [1:0]              in_cnt_r;
  drain_t                  drain_r;
  logic [ARRAY-1:0][IN_W:0] buf0_re_r, buf0_im_r, buf1_re_r, buf1_im_r;

  logic [1:0]              idx_s;
  drain_t                  drain_nxt_s;
  logic                    en_nxt_s;
  logic [1:0]              cnt_nxt_s;
  logic [ARRAY-1:0][IN_W:0] re_nxt_s, im_nxt_s;
  logic [ARRAY-1:0][IN_W:0] s0_re_s, s0_im_s, s1_re_s, s1_im_s;
  logic [ARRAY-1:0][IN_W:0] d0_re_s, d0_im_s, d1_re_s, d1_im_s;
  logic [ARRAY-1:0][IN_W:0] b0_re_nxt_s, b0_im_nxt_s, b1_re_nxt_s, b1_im_nxt_s;

  // Lane-wise butterfly arithmetic against both buffer slots.
  always_comb begin
    for (int i = 0; i < ARRAY; i++) begin
      s0_re_s[i] = $signed(buf0_re_r[i]) + sext(din_re[i]);
      s0_im_s[i] = $signed(buf0_im_r[i]) + sext(din_im[i]);
      d0_re_s[i] = $signed(buf0_re_r[i]) - sext(din_re[i]);
      d0_im_s[i] = $signed(buf0_im_r[i]) - sext(din_im[i]);
      s1_re_s[i] = $signed(buf1_re_r[i]) + sext(din_re[i]);
      s1_im_s[i] = $signed(buf1_im_r[i]) + sext(din_im[i]);
      d1_re_s[i] = $signed(buf1_re_r[i]) - sext(din_re[i]);
      d1_im_s[i] = $signed(buf1_im_r[i]) - sext(din_im[i]);
    end
  end

  // Block index, buffer next-state and output selection.
  always_comb begin
    idx_s       = din_sop ? 2'd0 : in_cnt_r;
    drain_nxt_s = DR_IDLE;
    en_nxt_s    = 1'b0;
    cnt_nxt_s   = 2'd0;
    re_nxt_s    = {(ARRAY*OW){1'b0}};
    im_nxt_s    = {(ARRAY*OW){1'b0}};
    b0_re_nxt_s = buf0_re_r;
    b0_im_nxt_s = buf0_im_r;
    b1_re_nxt_s = buf1_re_r;
    b1_im_nxt_s = buf1_im_r;

    case ({din_en, idx_s})
      3'b100: begin
        for (int i = 0; i < ARRAY; i++) begin
          b0_re_nxt_s[i] = sext(din_re[i]);
          b0_im_nxt_s[i] = sext(din_im[i]);
        end
      end
      3'b101: begin
        for (int i = 0; i < ARRAY; i++) begin
          b1_re_nxt_s[i] = sext(din_re[i]);
          b1_im_nxt_s[i] = sext(din_im[i]);
        end
      end
      3'b110: begin
        b0_re_nxt_s = d0_re_s;
        b0_im_nxt_s = d0_im_s;
      end
      3'b111: begin
        b1_re_nxt_s = d1_re_s;
        b1_im_nxt_s = d1_im_s;
      end
      default: begin
        b0_re_nxt_s = buf0_re_r;
        b1_re_nxt_s = buf1_re_r;
      end
    endcase

    // Drain reads the slot before any same-cycle overwrite by the next frame.
    case (drain_r)
      DR_BUF0: begin
        drain_nxt_s = DR_BUF1;
        en_nxt_s    = 1'b1;
        cnt_nxt_s   = 2'd2;
        re_nxt_s    = buf0_re_r;
        im_nxt_s    = buf0_im_r;
      end
      DR_BUF1: begin
        drain_nxt_s = DR_IDLE;
        en_nxt_s    = 1'b1;
        cnt_nxt_s   = 2'd3;
        re_nxt_s    = buf1_re_r;
        im_nxt_s    = buf1_im_r;
      end
      default: begin
        case ({din_en, idx_s})
          3'b110: begin
            en_nxt_s  = 1'b1;
            cnt_nxt_s = 2'd0;
            re_nxt_s  = s0_re_s;
            im_nxt_s  = s0_im_s;
          end
          3'b111: begin
            drain_nxt_s = DR_BUF0;
            en_nxt_s    = 1'b1;
            cnt_nxt_s   = 2'd1;
            re_nxt_s    = s1_re_s;
            im_nxt_s    = s1_im_s;
          end
          default: begin
            en_nxt_s = 1'b0;
          end
        endcase
      end
    endcase
  end

  // State, buffers and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_cnt_r  <= 2'd0;
      drain_r   <= DR_IDLE;
      buf0_re_r <= {(ARRAY*OW){1'b0}};
      buf0_im_r <= {(ARRAY*OW){1'b0}};
      buf1_re_r <= {(ARRAY*OW){1'b0}};
      buf1_im_r <= {(ARRAY*OW){1'b0}};
      bfly_en   <= 1'b0;
      bfly_cnt  <= 2'd0;
      dout_re   <= {(ARRAY*OW){1'b0}};
      dout_im   <= {(ARRAY*OW){1'b0}};
    end else begin
      if (din_en) begin
        in_cnt_r <= idx_s + 2'd1;
      end else begin
        in_cnt_r <= in_cnt_r;
      end
      drain_r   <= drain_nxt_s;
      buf0_re_r <= b0_re_nxt_s;
      buf0_im_r <= b0_im_nxt_s;
      buf1_re_r <= b1_re_nxt_s;
      buf1_im_r <= b1_im_nxt_s;
      bfly_en   <= en_nxt_s;
      bfly_cnt  <= cnt_nxt_s;
      dout_re   <= re_nxt_s;
      dout_im   <= im_nxt_s;
    end
  end

endmodule

// File: tb/tb_fft_bfly_stage0.sv
// Directed bench for fft_bfly_stage0: table-driven single frames plus
// back-to-back, stall, restart and mid-drain reset sequences.
module tb_fft_bfly_stage0;
  localparam int IN_W  = 9;
  localparam int ARRAY = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic din_en = 1'b0;
  logic din_sop = 1'b0;
  logic [ARRAY-1:0][IN_W-1:0] din_re, din_im;
  logic bfly_en;
  logic [1:0] bfly_cnt;
  logic [ARRAY-1:0][IN_W:0] dout_re, dout_im;

  int n_chk = 0;
  int n_pass = 0;
  int er[ARRAY];
  int ei[ARRAY];

  typedef struct {
    string name;
    int    b_re[4];
    int    b_im[4];
    int    e_re[4];
    int    e_im[4];
  } vec_t;
  vec_t tbl[3];

  fft_bfly_stage0 #(.IN_W(IN_W), .ARRAY(ARRAY)) dut (
    .clk(clk), .rstn(rstn), .din_en(din_en), .din_sop(din_sop),
    .din_re(din_re), .din_im(din_im), .bfly_en(bfly_en), .bfly_cnt(bfly_cnt),
    .dout_re(dout_re), .dout_im(dout_im)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_u(input logic en, input logic sop, input int re, input int im);
    din_en = en;
    din_sop = sop;
    for (int j = 0; j < ARRAY; j++) begin
      din_re[j] = IN_W'(re);
      din_im[j] = IN_W'(im);
    end
  endtask

  task automatic drive_lane(input logic sop);
    din_en = 1'b1;
    din_sop = sop;
    for (int j = 0; j < ARRAY; j++) begin
      din_re[j] = IN_W'(j);
      din_im[j] = IN_W'(-j);
    end
  endtask

  task automatic exp_u(input int re, input int im);
    for (int j = 0; j < ARRAY; j++) begin
      er[j] = re;
      ei[j] = im;
    end
  endtask

  task automatic exp_lane2();
    for (int j = 0; j < ARRAY; j++) begin
      er[j] = 2 * j;
      ei[j] = -2 * j;
    end
  endtask

  task automatic check(input string nm, input logic een, input logic [1:0] ecnt);
    bit ok;
    int bad;
    ok = 1'b1;
    bad = 0;
    n_chk++;
    if (bfly_en !== een || bfly_cnt !== ecnt) ok = 1'b0;
    for (int j = ARRAY - 1; j >= 0; j--) begin
      if ($signed(dout_re[j]) !== er[j] || $signed(dout_im[j]) !== ei[j]) begin
        ok = 1'b0;
        bad = j;
      end
    end
    if (ok) n_pass++;
    else $display("FAIL %s: got en=%b cnt=%0d lane%0d re=%0d im=%0d, required en=%b cnt=%0d re=%0d im=%0d",
                  nm, bfly_en, bfly_cnt, bad, $signed(dout_re[bad]), $signed(dout_im[bad]),
                  een, ecnt, er[bad], ei[bad]);
  endtask

  task automatic run_vec(input int v, input logic first_sop);
    for (int k = 0; k < 4; k++) begin
      drive_u(1'b1, (k == 0) ? first_sop : 1'b0, tbl[v].b_re[k], tbl[v].b_im[k]);
      step();
      if (k < 2) begin
        exp_u(0, 0);
        check({tbl[v].name, "_quiet"}, 1'b0, 2'd0);
      end else begin
        exp_u(tbl[v].e_re[k-2], tbl[v].e_im[k-2]);
        check({tbl[v].name, "_sum"}, 1'b1, 2'(k - 2));
      end
    end
    drive_u(1'b0, 1'b0, 0, 0);
    step();
    exp_u(tbl[v].e_re[2], tbl[v].e_im[2]);
    check({tbl[v].name, "_diff0"}, 1'b1, 2'd2);
    step();
    exp_u(tbl[v].e_re[3], tbl[v].e_im[3]);
    check({tbl[v].name, "_diff1"}, 1'b1, 2'd3);
    step();
    exp_u(0, 0);
    check({tbl[v].name, "_idle"}, 1'b0, 2'd0);
  endtask

  initial begin
    tbl[0].name = "single";
    tbl[0].b_re = '{100, -50, 20, 255};
    tbl[0].b_im = '{0, 0, 0, 0};
    tbl[0].e_re = '{120, 205, 80, -305};
    tbl[0].e_im = '{0, 0, 0, 0};
    tbl[1].name = "extreme";
    tbl[1].b_re = '{-256, 255, 255, -256};
    tbl[1].b_im = '{-256, 255, 255, -256};
    tbl[1].e_re = '{-1, -1, -511, 511};
    tbl[1].e_im = '{-1, -1, -511, 511};
    tbl[2].name = "mixed";
    tbl[2].b_re = '{7, -3, -10, 4};
    tbl[2].b_im = '{-100, 50, 30, -8};
    tbl[2].e_re = '{-3, 1, 17, -7};
    tbl[2].e_im = '{-70, 42, -130, 58};

    drive_u(1'b0, 1'b0, 0, 0);
    #12;
    exp_u(0, 0);
    check("reset_state", 1'b0, 2'd0);
    rstn = 1'b1;
    step();

    for (int v = 0; v < 3; v++) run_vec(v, 1'b1);

    // Back-to-back: frame A (single) then lane-index frame B.
    for (int k = 0; k < 4; k++) begin
      drive_u(1'b1, k == 0, tbl[0].b_re[k], tbl[0].b_im[k]);
      step();
      if (k >= 2) begin
        exp_u(tbl[0].e_re[k-2], 0);
        check("b2b_a_sum", 1'b1, 2'(k - 2));
      end
    end
    drive_lane(1'b1);
    step();
    exp_u(80, 0);
    check("b2b_a_diff0", 1'b1, 2'd2);
    drive_lane(1'b0);
    step();
    exp_u(-305, 0);
    check("b2b_a_diff1", 1'b1, 2'd3);
    drive_lane(1'b0);
    step();
    exp_lane2();
    check("b2b_b_sum0", 1'b1, 2'd0);
    drive_lane(1'b0);
    step();
    exp_lane2();
    check("b2b_b_sum1", 1'b1, 2'd1);
    drive_u(1'b0, 1'b0, 0, 0);
    step();
    exp_u(0, 0);
    check("b2b_b_diff0", 1'b1, 2'd2);
    step();
    check("b2b_b_diff1", 1'b1, 2'd3);
    step();
    check("b2b_end", 1'b0, 2'd0);

    // Stall: one idle between B1/B2, two between B2/B3.
    drive_u(1'b1, 1'b1, 100, 0); step();
    drive_u(1'b1, 1'b0, -50, 0); step();
    drive_u(1'b0, 1'b0, 0, 0);   step();
    exp_u(0, 0);
    check("stall_gap1", 1'b0, 2'd0);
    drive_u(1'b1, 1'b0, 20, 0);  step();
    exp_u(120, 0);
    check("stall_sum0", 1'b1, 2'd0);
    drive_u(1'b0, 1'b0, 0, 0);   step();
    exp_u(0, 0);
    check("stall_gap2a", 1'b0, 2'd0);
    step();
    check("stall_gap2b", 1'b0, 2'd0);
    drive_u(1'b1, 1'b0, 255, 0); step();
    exp_u(205, 0);
    check("stall_sum1", 1'b1, 2'd1);
    drive_u(1'b0, 1'b0, 0, 0);   step();
    exp_u(80, 0);
    check("stall_diff0", 1'b1, 2'd2);
    step();
    exp_u(-305, 0);
    check("stall_diff1", 1'b1, 2'd3);
    step();
    exp_u(0, 0);
    check("stall_end", 1'b0, 2'd0);

    // Restart after B2 of frame A, then full frame B.
    for (int k = 0; k < 3; k++) begin
      drive_u(1'b1, k == 0, tbl[0].b_re[k], tbl[0].b_im[k]);
      step();
    end
    exp_u(120, 0);
    check("restart_a_sum0", 1'b1, 2'd0);
    run_vec(2, 1'b1);

    // Reset pulsed during the drain; fresh frame begins at index 0 without sop.
    for (int k = 0; k < 4; k++) begin
      drive_u(1'b1, k == 0, tbl[0].b_re[k], tbl[0].b_im[k]);
      step();
    end
    drive_u(1'b0, 1'b0, 0, 0);
    step();
    exp_u(80, 0);
    check("rst_pre_drain", 1'b1, 2'd2);
    #2;
    rstn = 1'b0;
    #1;
    exp_u(0, 0);
    check("rst_async", 1'b0, 2'd0);
    step();
    check("rst_held", 1'b0, 2'd0);
    rstn = 1'b1;
    run_vec(1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
